banner_pixel_streamer: RTL and testbench

//  Reader for the 1440-bit text-banner pixel map (10 glyphs x 12x12 font cells, 120 cols x 12 rows).

---
 rtl/banner_pixel_streamer_pkg.sv | 39 +++
 rtl/banner_pixel_streamer_if.sv | 24 ++
 rtl/banner_pixel_streamer_raster_counter.sv | 61 ++++++
 rtl/banner_pixel_streamer.sv | 88 ++++++++
 tb/tb_banner_pixel_streamer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/banner_pixel_streamer_pkg.sv
// Shared constants, state type and map addressing for the banner pixel streamer.
// Optional build macro SCALE2X_EN doubles each map pixel in x and y (240x24 output).
package banner_pkg;

  localparam int BANNER_COLS  = 120;
  localparam int BANNER_ROWS  = 12;
  localparam int BANNER_MAP_W = BANNER_COLS * BANNER_ROWS;
  localparam int BANNER_GLYPH = 12;
  localparam int BANNER_X_W   = 8;
  localparam int BANNER_Y_W   = 5;
  localparam int BANNER_IDX_W = 11;

`ifdef SCALE2X_EN
  localparam int BANNER_SCALE_SH = 1;
`else
  localparam int BANNER_SCALE_SH = 0;
`endif

  localparam int BANNER_OUT_COLS = BANNER_COLS << BANNER_SCALE_SH;
  localparam int BANNER_OUT_ROWS = BANNER_ROWS << BANNER_SCALE_SH;

  typedef enum logic {
    IDLE,
    STREAM
  } banner_state_t;

  // Output coordinate -> pixel_map bit; MSB is the top-left pixel.
  function automatic logic [BANNER_IDX_W-1:0] banner_map_idx(
    input logic [BANNER_X_W-1:0] x,
    input logic [BANNER_Y_W-1:0] y
  );
    logic [BANNER_X_W-1:0] col;
    logic [BANNER_Y_W-1:0] row;
    col = x >> BANNER_SCALE_SH;
    row = y >> BANNER_SCALE_SH;
    return BANNER_IDX_W'(BANNER_MAP_W - 1 - (int'(row) * BANNER_COLS + int'(col)));
  endfunction

endpackage

// File: rtl/banner_pixel_streamer_if.sv
// Pixel stream interface: one banner pixel per valid/ready transfer with coordinates and row/frame flags.
interface banner_pixel_streamer_if
  import banner_pkg::*;
();

  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_data;
  logic [BANNER_X_W-1:0] pix_x;
  logic [BANNER_Y_W-1:0] pix_y;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/banner_pixel_streamer_raster_counter.sv
// Raster x/y counter over the output grid (scale aware); exposes current and next coordinates
// so the streamer can register the matching map bit in the same cycle the counter advances.
module banner_raster_counter
  import banner_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  adv_i,
  output logic [BANNER_X_W-1:0] x_o,
  output logic [BANNER_Y_W-1:0] y_o,
  output logic [BANNER_X_W-1:0] x_nxt_o,
  output logic [BANNER_Y_W-1:0] y_nxt_o,
  output logic                  eol_o,
  output logic                  eof_o
);

  localparam logic [BANNER_X_W-1:0] LAST_X = BANNER_X_W'(BANNER_OUT_COLS - 1);
  localparam logic [BANNER_Y_W-1:0] LAST_Y = BANNER_Y_W'(BANNER_OUT_ROWS - 1);

  logic [BANNER_X_W-1:0] x_q, x_d;
  logic [BANNER_Y_W-1:0] y_q, y_d;
  logic                  eol, eof;

  always_comb begin
    eol = (x_q == LAST_X);
    eof = eol && (y_q == LAST_Y);
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (eol) begin
        x_d = '0;
        // Wrap to (0,0) after the last pixel so an idle counter is always at the origin.
        y_d = eof ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign x_nxt_o = x_d;
  assign y_nxt_o = y_d;
  assign eol_o   = eol;
  assign eof_o   = eof;

endmodule

// File: rtl/banner_pixel_streamer.sv
// Latches a 1440-bit banner map on load and streams it pixel by pixel in raster order.
// Build option SCALE2X_EN (see banner_pkg) selects 2x pixel doubling.
module banner_pixel_streamer
  import banner_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [BANNER_MAP_W-1:0] pixel_map_i,
  output logic                    busy_o,
  banner_pixel_streamer_if.master pix
);

  banner_state_t           state_q, state_d;
  logic [BANNER_MAP_W-1:0] map_q, map_d;
  logic                    data_q, data_d;
  logic                    start, adv, xfer;

  logic [BANNER_X_W-1:0] x_cur, x_nxt;
  logic [BANNER_Y_W-1:0] y_cur, y_nxt;
  logic                  eol, eof;

  banner_raster_counter u_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (start),
    .adv_i   (adv),
    .x_o     (x_cur),
    .y_o     (y_cur),
    .x_nxt_o (x_nxt),
    .y_nxt_o (y_nxt),
    .eol_o   (eol),
    .eof_o   (eof)
  );

  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    data_d  = data_q;
    start   = 1'b0;
    adv     = 1'b0;
    xfer    = (state_q == STREAM) && pix.pix_ready;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = STREAM;
          map_d   = pixel_map_i;
          start   = 1'b1;
          // First pixel (0,0) comes straight from the incoming map.
          data_d  = pixel_map_i[BANNER_MAP_W-1];
        end
      end
      STREAM: begin
        if (xfer) begin
          adv = 1'b1;
          if (eof) begin
            state_d = IDLE;
            data_d  = 1'b0;
          end else begin
            data_d = map_q[banner_map_idx(x_nxt, y_nxt)];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      map_q   <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      data_q  <= data_d;
    end
  end

  assign busy_o        = (state_q == STREAM);
  assign pix.pix_valid = (state_q == STREAM);
  assign pix.pix_data  = data_q;
  assign pix.pix_x     = x_cur;
  assign pix.pix_y     = y_cur;
  assign pix.pix_eol   = eol;
  assign pix.pix_eof   = eof;

endmodule

// File: tb/tb_banner_pixel_streamer.sv
// Randomized bench for banner_pixel_streamer against a raster-order pixel model.
module tb_banner_pixel_streamer;
  import banner_pkg::*;

`ifdef SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int OC    = 120 * S;
  localparam int OR    = 12 * S;
  localparam int TOTAL = OC * OR;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [1439:0] map;
  logic         busy;

  banner_pixel_streamer_if pix ();

  banner_pixel_streamer dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (load),
    .pixel_map_i (map),
    .busy_o      (busy),
    .pix         (pix)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int eol_cnt;
  int cyc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1439:0] rand_map();
    logic [1439:0] m;
    for (int i = 0; i < 45; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  task automatic run_frame(input logic [1439:0] m, input int pct, input bit toggle,
                           input bit pulse_loads, input int abort_at);
    int k = 0;
    int cyc = 0;
    int ex, ey;
    logic ed;
    @(negedge clk);
    map  = m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("busy_start", busy, 1);
    eol_cnt = 0;
    while (k < TOTAL && cyc < 40000) begin
      load = 1'b0;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix.pix_valid, 0);
        chk("abort_x", 32'(pix.pix_x), 0);
        chk("abort_y", 32'(pix.pix_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ex = k % OC;
      ey = k / OC;
      ed = m[1439 - ((ey / S) * 120 + ex / S)];
      chk("valid", pix.pix_valid, 1);
      chk("busy", busy, 1);
      chk("x", 32'(pix.pix_x), 32'(ex));
      chk("y", 32'(pix.pix_y), 32'(ey));
      chk("data", pix.pix_data, ed);
      chk("eol", pix.pix_eol, (ex == OC - 1));
      chk("eof", pix.pix_eof, (ex == OC - 1) && (ey == OR - 1));
      pix.pix_ready = ($urandom_range(99) < pct);
      if (toggle) map = rand_map();
      if (pulse_loads && (cyc == 200 || (k == TOTAL - 1 && pix.pix_ready))) begin
        load = 1'b1;
        map  = ~m;
      end
      if (pix.pix_ready) begin
        if (ex == OC - 1) eol_cnt++;
        k++;
      end
      cyc++;
      @(negedge clk);
    end
    load = 1'b0;
    pix.pix_ready = 1'b1;
    cyc_cnt = cyc;
    chk("frame_len", k, TOTAL);
    chk("busy_end", busy, 0);
    chk("valid_end", pix.pix_valid, 0);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("valid_idle", pix.pix_valid, 0);
  endtask

  initial begin
    logic [1439:0] m;
    rst_n = 1'b0;
    load  = 1'b0;
    map   = '0;
    pix.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix.pix_valid, 0);
    chk("rst_data", pix.pix_data, 0);
    chk("rst_x", 32'(pix.pix_x), 0);
    chk("rst_y", 32'(pix.pix_y), 0);
    chk("rst_eol", pix.pix_eol, 0);
    chk("rst_eof", pix.pix_eof, 0);
    rst_n = 1'b1;

    // reset mid-frame at (37,4), then restart
    run_frame(rand_map(), 100, 1'b0, 1'b0, 4 * OC + 37);
    @(negedge clk);
    chk("post_abort_busy", busy, 0);
    run_frame(rand_map(), 100, 1'b0, 1'b0, -1);
    chk("restart_cycles", cyc_cnt, TOTAL);

    // top-left pixel only
    m = '0;
    m[1439] = 1'b1;
    run_frame(m, 100, 1'b0, 1'b0, -1);
    chk("tl_cycles", cyc_cnt, TOTAL);

    // bottom-right pixel only
    m = '0;
    m[0] = 1'b1;
    run_frame(m, 100, 1'b0, 1'b0, -1);
    chk("br_eol_count", eol_cnt, OR);

    // checkerboard with random backpressure
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 120; c++)
        m[1439 - (r * 120 + c)] = ((r + c) % 2 == 1);
    run_frame(m, 50, 1'b0, 1'b0, -1);
    chk("ckr_eol_count", eol_cnt, OR);

    // loads while busy are ignored; a new load afterwards takes the new map
    m = rand_map();
    run_frame(m, 50, 1'b0, 1'b1, -1);
    run_frame(~m, 100, 1'b0, 1'b0, -1);

    // map input churning during the frame
    run_frame(rand_map(), 70, 1'b1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
